// File: rtl/encoder_pkg.sv
// -----------------------------------------------------------------------------
// encoder_pkg
//
// Shared definitions for the encoder register block and the sampler that
// arbitrates its MMIO port:
//   - register offsets of the encoder block
//   - bus word type and a packed bus command used by the sampler's bus mux
//   - FSM state encoding of the sampler
// -----------------------------------------------------------------------------
package encoder_pkg;

    typedef logic [31:0] bus_word_t;

    // Encoder register block offsets.
    localparam bus_word_t REG_CTRL     = 32'h0000_0000;
    localparam bus_word_t REG_STATUS   = 32'h0000_0004;
    localparam bus_word_t REG_POSITION = 32'h0000_0008;
    localparam bus_word_t REG_VELOCITY = 32'h0000_000C;

    // Sampler sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        HOST_RD,
        SAMP_POS,
        SAMP_VEL,
        SAMP_CAP
    } state_e;

    // One cycle of traffic on the encoder MMIO port.
    typedef struct packed {
        logic      we;
        logic      re;
        bus_word_t addr;
        bus_word_t wdata;
    } bus_cmd_t;

    localparam bus_cmd_t BUS_IDLE = '{we: 1'b0, re: 1'b0, addr: '0, wdata: '0};

    // Sampler-issued read of one encoder register.
    function automatic bus_cmd_t bus_read(input bus_word_t addr);
        bus_cmd_t cmd;
        cmd      = BUS_IDLE;
        cmd.re   = 1'b1;
        cmd.addr = addr;
        return cmd;
    endfunction

endpackage

// File: rtl/encoder_sampler_if.sv
// -----------------------------------------------------------------------------
// encoder_sampler_if
//
// Host-side request/response signals plus the downstream MMIO port of the
// encoder register block, bundled so the sampler sees one port.
//
//   host_req/host_we/host_addr/host_wdata : host request, held until accepted
//   host_ready                            : request accepted this cycle
//   host_rvalid/host_rdata                : 1-cycle read response
//   bus_addr/bus_we/bus_re/bus_wdata      : commands to the encoder block
//   bus_rdata                             : registered read data (cycle after re)
//
// Modports:
//   slave  : the sampler (consumes host requests, drives the encoder bus)
//   master : the environment (host + encoder block)
// -----------------------------------------------------------------------------
interface encoder_sampler_if;
    import encoder_pkg::*;

    logic      host_req;
    logic      host_we;
    bus_word_t host_addr;
    bus_word_t host_wdata;
    logic      host_ready;
    logic      host_rvalid;
    bus_word_t host_rdata;

    bus_word_t bus_addr;
    logic      bus_we;
    logic      bus_re;
    bus_word_t bus_wdata;
    bus_word_t bus_rdata;

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_ready, host_rvalid, host_rdata,
        output bus_addr, bus_we, bus_re, bus_wdata,
        input  bus_rdata
    );

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_ready, host_rvalid, host_rdata,
        input  bus_addr, bus_we, bus_re, bus_wdata,
        output bus_rdata
    );

endinterface

// File: rtl/encoder_sample_timer.sv
// -----------------------------------------------------------------------------
// encoder_sample_timer
//
// Period counter for the autonomous sampler. While enabled with a non-zero
// period it counts 0..sample_period-1 and ticks on the last count. A tick
// sets a pending request that the sequencer consumes when it starts a
// sample; a tick that finds a request still pending raises a sticky overrun.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   sample_en       : enable periodic sampling
//   sample_period   : cycles between ticks, 0 disables the timer
//   ovr_clr         : clear overrun (a simultaneous new overrun wins)
//   sample_start    : sequencer is issuing the position read this cycle
//   sample_due      : a sample is requested (pending, or ticking right now)
//   overrun         : sticky overrun flag
// -----------------------------------------------------------------------------
module encoder_sample_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_en,
    input  logic [PERIOD_W-1:0] sample_period,
    input  logic                ovr_clr,
    input  logic                sample_start,
    output logic                sample_due,
    output logic                overrun
);

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] count_q;
    logic                tick_pending_q;
    logic                run;
    logic                tick;
    logic                overrun_event;

    assign run  = sample_en && (sample_period != '0);
    // >= rather than == so a period shrunk below the current count still
    // wraps instead of running all the way round the counter.
    assign tick = run && (count_q >= sample_period - ONE);

    assign overrun_event = tick && tick_pending_q;

    // Including the live tick lets an idle sequencer start in the tick cycle
    // itself rather than one cycle later.
    assign sample_due = tick_pending_q || tick;

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every statement here
        // reads the pre-edge values, independent of statement order.
        if (reset) begin
            count_q        <= '0;
            tick_pending_q <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            if (!run) begin
                count_q        <= '0;
                tick_pending_q <= 1'b0;
            end else begin
                count_q <= tick ? '0 : count_q + ONE;
                // A new tick outranks the consume in the same cycle.
                if (tick) begin
                    tick_pending_q <= 1'b1;
                end else if (sample_start) begin
                    tick_pending_q <= 1'b0;
                end
            end

            // Set has priority over clear.
            if (overrun_event) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/encoder_sampler.sv
// -----------------------------------------------------------------------------
// encoder_sampler
//
// Shares the encoder register block's MMIO port between a host and a periodic
// sampler. Host accesses pass straight through while the sampler is idle; a
// pending sample takes priority and performs back-to-back reads of POSITION
// and VELOCITY, then publishes both in the same cycle with a samp_valid pulse.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   bus_if          : host request/response and encoder MMIO port (slave)
//   sample_en       : enable periodic sampling
//   sample_period   : cycles between sample ticks, 0 disables sampling
//   ovr_clr         : clear the overrun flag
//   samp_valid      : 1-cycle pulse, snapshot updated
//   samp_position   : last sampled position
//   samp_velocity   : last sampled velocity
//   overrun         : sticky, a tick arrived while one was still pending
// -----------------------------------------------------------------------------
module encoder_sampler
    import encoder_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    encoder_sampler_if.slave    bus_if,
    input  logic                sample_en,
    input  logic [PERIOD_W-1:0] sample_period,
    input  logic                ovr_clr,
    output logic                samp_valid,
    output logic [31:0]         samp_position,
    output logic [31:0]         samp_velocity,
    output logic                overrun
);

    state_e    state_q;
    bus_word_t pos_hold_q;
    bus_cmd_t  cmd;
    logic      host_ready;
    logic      host_rvalid;
    bus_word_t host_rdata;
    logic      sample_due;
    logic      sample_start;

    assign sample_start = (state_q == SAMP_POS);

    encoder_sample_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .sample_en     (sample_en),
        .sample_period (sample_period),
        .ovr_clr       (ovr_clr),
        .sample_start  (sample_start),
        .sample_due    (sample_due),
        .overrun       (overrun)
    );

    // Bus mux and host handshake. Host requests are forwarded in the same
    // cycle they are accepted, so this path is combinational.
    always_comb begin
        // NOTE: every output gets a default first; a branch that forgot one
        // would otherwise infer a latch.
        cmd         = BUS_IDLE;
        host_ready  = 1'b0;
        host_rvalid = 1'b0;
        host_rdata  = '0;

        unique case (state_q)
            IDLE: begin
                // A pending sample blocks the host; reset blocks acceptance
                // so nothing reaches the encoder while the sequencer clears.
                if (!sample_due && bus_if.host_req && !reset) begin
                    host_ready = 1'b1;
                    cmd.we     = bus_if.host_we;
                    cmd.re     = !bus_if.host_we;
                    cmd.addr   = bus_if.host_addr;
                    cmd.wdata  = bus_if.host_we ? bus_if.host_wdata : '0;
                end
            end
            HOST_RD: begin
                host_rvalid = 1'b1;
                host_rdata  = bus_if.bus_rdata;
            end
            SAMP_POS: cmd = bus_read(REG_POSITION);
            SAMP_VEL: cmd = bus_read(REG_VELOCITY);
            SAMP_CAP: cmd = BUS_IDLE;
            default:  cmd = BUS_IDLE;
        endcase
    end

    assign bus_if.bus_we      = cmd.we;
    assign bus_if.bus_re      = cmd.re;
    assign bus_if.bus_addr    = cmd.addr;
    assign bus_if.bus_wdata   = cmd.wdata;
    assign bus_if.host_ready  = host_ready;
    assign bus_if.host_rvalid = host_rvalid;
    assign bus_if.host_rdata  = host_rdata;

    // Sequencer. bus_rdata is registered by the encoder block, so each read's
    // data is captured one state after the read is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            // NOTE: the holding register is cleared as well, so a reset in the
            // middle of a sequence cannot leak a stale half-snapshot later.
            pos_hold_q    <= '0;
            samp_position <= '0;
            samp_velocity <= '0;
            samp_valid    <= 1'b0;
        end else begin
            samp_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (sample_due) begin
                        state_q <= SAMP_POS;
                    end else if (host_ready && !bus_if.host_we) begin
                        state_q <= HOST_RD;
                    end
                end
                HOST_RD:  state_q <= IDLE;
                SAMP_POS: state_q <= SAMP_VEL;
                SAMP_VEL: begin
                    pos_hold_q <= bus_if.bus_rdata;
                    state_q    <= SAMP_CAP;
                end
                SAMP_CAP: begin
                    // Both halves update together: the snapshot is never torn.
                    samp_position <= pos_hold_q;
                    samp_velocity <= bus_if.bus_rdata;
                    samp_valid    <= 1'b1;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_sampler.sv
// -----------------------------------------------------------------------------
// tb_encoder_sampler
//
// Drives encoder_sampler with directed scenarios followed by randomized host
// traffic and sampler configurations. A register-array model of the encoder
// block sits on the MMIO port. Expected behaviour comes from a schedule-based
// reference: it tracks when the port becomes free again, when a sample was
// started (and therefore when its reads and its result appear), and derives
// ticks from the number of cycles the timer has been running modulo the period.
// -----------------------------------------------------------------------------
module tb_encoder_sampler;
    import encoder_pkg::*;

    localparam int PERIOD_W = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                sample_en;
    logic [PERIOD_W-1:0] sample_period;
    logic                ovr_clr;
    logic                samp_valid;
    logic [31:0]         samp_position;
    logic [31:0]         samp_velocity;
    logic                overrun;

    always #5 clk = ~clk;

    encoder_sampler_if bus_if ();

    encoder_sampler #(
        .PERIOD_W (PERIOD_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus_if        (bus_if),
        .sample_en     (sample_en),
        .sample_period (sample_period),
        .ovr_clr       (ovr_clr),
        .samp_valid    (samp_valid),
        .samp_position (samp_position),
        .samp_velocity (samp_velocity),
        .overrun       (overrun)
    );

    // Encoder register block: write in place, registered read data.
    logic [31:0] enc_regs [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] enc_rdata = 32'h0;
    assign bus_if.bus_rdata = enc_rdata;

    always @(posedge clk) begin
        if (bus_if.bus_we) enc_regs[bus_if.bus_addr[3:2]] <= bus_if.bus_wdata;
        if (bus_if.bus_re) enc_rdata <= enc_regs[bus_if.bus_addr[3:2]];
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    int          cyc;
    int          free_at;      // first cycle the port is free for a new job
    int          samp_start;   // cycle a sample sequence was started
    int          rd_accept;    // cycle the last host read was accepted
    int          run_len;      // consecutive cycles the timer has been running
    bit          m_pend;
    bit          m_ovr;
    logic [31:0] m_regs [4];
    logic [31:0] m_pos, m_vel, due_pos, due_vel, rd_exp;
    bit          last_ready;
    int          pulse_q [$];

    // Observed values of the most recent cycle, for directed checks.
    logic        o_ready, o_we, o_re, o_rvalid, o_valid, o_ovr;
    logic [31:0] o_addr, o_wdata, o_rdata, o_pos, o_vel;

    task automatic model_reset();
        free_at    = cyc + 1;
        samp_start = -100;
        rd_accept  = -100;
        run_len    = 0;
        m_pend     = 1'b0;
        m_ovr      = 1'b0;
        m_pos      = '0;
        m_vel      = '0;
    endtask

    // One clock cycle: predict, compare at negedge, advance, move to #1 after
    // the next posedge where the caller sets the following cycle's inputs.
    task automatic run_cycle();
        bit          run, tick, idle, due, e_ready, e_we, e_re, e_rvalid, e_valid, chk_wdata;
        bit          ovr_event;
        logic [31:0] e_addr, e_wdata;
        int          per;

        per  = int'(sample_period);
        run  = sample_en && (per != 0);
        tick = 1'b0;
        if (run) tick = ((run_len % per) == per - 1);
        idle = (cyc >= free_at);
        due  = m_pend || tick;

        e_ready   = idle && !due && bus_if.host_req && !reset;
        e_we      = 1'b0;
        e_re      = 1'b0;
        e_addr    = '0;
        e_wdata   = '0;
        chk_wdata = 1'b1;
        if (e_ready) begin
            e_we   = bus_if.host_we;
            e_re   = !bus_if.host_we;
            e_addr = bus_if.host_addr;
            if (bus_if.host_we) e_wdata = bus_if.host_wdata;
            else chk_wdata = 1'b0;
        end else if (cyc == samp_start + 1) begin
            e_re   = 1'b1;
            e_addr = 32'h08;
        end else if (cyc == samp_start + 2) begin
            e_re   = 1'b1;
            e_addr = 32'h0C;
        end
        e_rvalid = (cyc == rd_accept + 1);
        e_valid  = (cyc == samp_start + 4);
        if (e_valid) begin
            m_pos = due_pos;
            m_vel = due_vel;
        end

        @(negedge clk);
        o_ready  = bus_if.host_ready;
        o_we     = bus_if.bus_we;
        o_re     = bus_if.bus_re;
        o_addr   = bus_if.bus_addr;
        o_wdata  = bus_if.bus_wdata;
        o_rvalid = bus_if.host_rvalid;
        o_rdata  = bus_if.host_rdata;
        o_valid  = samp_valid;
        o_pos    = samp_position;
        o_vel    = samp_velocity;
        o_ovr    = overrun;
        if (o_valid === 1'b1) pulse_q.push_back(cyc);

        check("host_ready", o_ready, e_ready);
        check("samp_valid", o_valid, e_valid);
        check("samp_position", o_pos, m_pos);
        check("samp_velocity", o_vel, m_vel);
        check("overrun", o_ovr, m_ovr);
        if (!reset) begin
            check("bus_we", o_we, e_we);
            check("bus_re", o_re, e_re);
            check("bus_addr", o_addr, e_addr);
            if (chk_wdata) check("bus_wdata", o_wdata, e_wdata);
            check("host_rvalid", o_rvalid, e_rvalid);
            if (e_rvalid) check("host_rdata", o_rdata, rd_exp);
        end

        if (reset) begin
            model_reset();
        end else begin
            ovr_event = tick && m_pend;
            m_ovr     = ovr_event ? 1'b1 : (ovr_clr ? 1'b0 : m_ovr);
            m_pend    = run && (tick || (m_pend && (cyc != samp_start + 1)));
            run_len   = run ? run_len + 1 : 0;
            if (idle && due) begin
                samp_start = cyc;
                free_at    = cyc + 4;
                due_pos    = m_regs[2];
                due_vel    = m_regs[3];
            end else if (e_ready) begin
                if (bus_if.host_we) begin
                    m_regs[bus_if.host_addr[3:2]] = bus_if.host_wdata;
                end else begin
                    rd_accept = cyc;
                    rd_exp    = m_regs[bus_if.host_addr[3:2]];
                    free_at   = cyc + 2;
                end
            end
        end
        last_ready = e_ready;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Random host: keeps a request up until it is accepted, then maybe issues
    // another one.
    task automatic host_agent(input int req_pct, input bit read_only);
        if (bus_if.host_req && !last_ready) return;
        if (int'($urandom_range(99)) < req_pct) begin
            bus_if.host_req   = 1'b1;
            bus_if.host_we    = read_only ? 1'b0 : 1'($urandom_range(1));
            bus_if.host_addr  = 32'($urandom_range(3)) << 2;
            bus_if.host_wdata = $urandom;
        end else begin
            bus_if.host_req = 1'b0;
        end
    endtask

    task automatic host_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        bus_if.host_req   = 1'b1;
        bus_if.host_we    = we;
        bus_if.host_addr  = addr;
        bus_if.host_wdata = wdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waits;
        bit found;

        reset             = 1'b1;
        sample_en         = 1'b0;
        sample_period     = '0;
        ovr_clr           = 1'b0;
        bus_if.host_req   = 1'b0;
        bus_if.host_we    = 1'b0;
        bus_if.host_addr  = '0;
        bus_if.host_wdata = '0;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        due_pos    = '0;
        due_vel    = '0;
        rd_exp     = '0;
        last_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
        model_reset();

        // Reset values.
        run_cycle();
        run_cycle();
        reset = 1'b0;
        run_cycle();

        // Host write passes through in the same cycle, sampler disabled.
        host_access(1'b1, REG_CTRL, 32'h1);
        run_cycle();
        check("wr_ready", o_ready, 1'b1);
        check("wr_bus_we", o_we, 1'b1);
        check("wr_bus_addr", o_addr, 32'h0);
        check("wr_bus_wdata", o_wdata, 32'h1);

        // Host read: response the cycle after acceptance.
        host_access(1'b1, REG_POSITION, 32'h42);
        run_cycle();
        host_access(1'b0, REG_POSITION, 32'h0);
        run_cycle();
        check("rd_accept", o_ready, 1'b1);
        bus_if.host_req = 1'b0;
        run_cycle();
        check("rd_rvalid", o_rvalid, 1'b1);
        check("rd_rdata", o_rdata, 32'h42);

        // Periodic sampling, period 10, position 5, velocity -3.
        host_access(1'b1, REG_POSITION, 32'd5);
        run_cycle();
        host_access(1'b1, REG_VELOCITY, 32'hFFFF_FFFD);
        run_cycle();
        bus_if.host_req = 1'b0;
        sample_period   = 16'd10;
        sample_en       = 1'b1;
        pulse_q.delete();
        repeat (60) run_cycle();
        check("period10_pulses", pulse_q.size(), 5);
        for (int i = 1; i < pulse_q.size(); i++)
            check("period10_spacing", pulse_q[i] - pulse_q[i-1], 10);
        check("period10_pos", o_pos, 32'd5);
        check("period10_vel", o_vel, 32'hFFFF_FFFD);

        // Host request raised while a sample sequence holds the port.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            run_cycle();
            found = (samp_start == cyc - 1);
        end
        check("tick_found", found, 1'b1);
        host_access(1'b1, REG_CTRL, 32'h3);
        waits = 0;
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            if (last_ready) break;
            waits++;
        end
        check("held_req_wait", waits, 3);
        bus_if.host_req = 1'b0;
        repeat (12) run_cycle();
        check("held_req_pos", o_pos, 32'd5);
        check("held_req_vel", o_vel, 32'hFFFF_FFFD);

        // Period 1 with back-to-back host reads provokes overrun.
        sample_en = 1'b0;
        run_cycle();
        sample_period = 16'd1;
        sample_en     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            host_agent(100, 1'b1);
            run_cycle();
        end
        check("ovr_set", o_ovr, 1'b1);
        ovr_clr = 1'b1;
        run_cycle();
        ovr_clr = 1'b0;
        run_cycle();
        check("ovr_set_wins", o_ovr, 1'b1);
        sample_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            host_agent(0, 1'b1);
            run_cycle();
        end
        ovr_clr = 1'b1;
        run_cycle();
        ovr_clr = 1'b0;
        run_cycle();
        check("ovr_cleared", o_ovr, 1'b0);

        // Period 0: sampler stays silent.
        sample_period = 16'd0;
        sample_en     = 1'b1;
        repeat (6) run_cycle();
        pulse_q.delete();
        repeat (40) run_cycle();
        check("period0_pulses", pulse_q.size(), 0);

        // Reset while reading velocity.
        sample_period = 16'd10;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            run_cycle();
            found = (cyc == samp_start + 2);
        end
        check("vel_found", found, 1'b1);
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        pulse_q.delete();
        run_cycle();
        check("rst_vel_valid", o_valid, 1'b0);
        check("rst_vel_pos", o_pos, 32'h0);
        check("rst_vel_vel", o_vel, 32'h0);
        check("rst_vel_re", o_re, 1'b0);
        repeat (3) run_cycle();
        check("rst_vel_no_pulse", pulse_q.size(), 0);

        // Randomized traffic and configurations.
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                sample_en = 1'b0;
                host_agent(40, 1'b0);
                run_cycle();
                case ($urandom_range(5))
                    0: sample_period = 16'd0;
                    1: sample_period = 16'd1;
                    2: sample_period = 16'd2;
                    3: sample_period = 16'd5;
                    4: sample_period = 16'd7;
                    default: sample_period = 16'($urandom_range(20, 3));
                endcase
                sample_en = ($urandom_range(9) < 8);
            end else if ($urandom_range(49) == 0) begin
                sample_en = !sample_en;
            end
            ovr_clr = ($urandom_range(15) == 0);
            reset   = ($urandom_range(399) == 0);
            host_agent(40, 1'b0);
            run_cycle();
        end
        reset   = 1'b0;
        ovr_clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
